tt_um_jleugeri_ttt_sequencer: RTL and testbench

Controller that drives the time-multiplexed TTT processor core. It sweeps `processor_id` round-robin and issues the per-processor update/evaluate instruction pair. It also inserts host programming writes at processor boundaries and converts the core's `token_startstop` pulses into tagged start/stop events with a valid/ready handshake. It sits between the host/token-routing logic and the processor core.

---
 rtl/ttt_pkg.sv | 39 +++
 rtl/tt_um_jleugeri_ttt_slow_tick.sv | 25 ++
 rtl/tt_um_jleugeri_ttt_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared constants and types for the TTT processor sequencer:
// core instruction codes, token start/stop codes and the sequencer state enum.
package ttt_pkg;

  localparam logic [2:0] INSTR_NOP       = 3'b000;
  localparam logic [2:0] INSTR_PROG_DUR  = 3'b001;
  localparam logic [2:0] INSTR_PROG_GOOD = 3'b010;
  localparam logic [2:0] INSTR_PROG_BAD  = 3'b011;
  localparam logic [2:0] INSTR_UPDATE    = 3'b100;
  localparam logic [2:0] INSTR_EVAL      = 3'b101;

  localparam logic [1:0] SS_START = 2'b10;
  localparam logic [1:0] SS_STOP  = 2'b01;

  localparam logic [1:0] TGT_DISCARD = 2'b00;
  localparam logic [1:0] TGT_DUR     = 2'b01;
  localparam logic [1:0] TGT_GOOD    = 2'b10;
  localparam logic [1:0] TGT_BAD     = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DISPATCH,
    ST_PROG,
    ST_UPDATE,
    ST_EVAL,
    ST_CAPTURE
  } seq_state_t;

  // Map a host programming target onto the core write instruction.
  function automatic logic [2:0] prog_instr(input logic [1:0] tgt);
    case (tgt)
      TGT_DUR:  return INSTR_PROG_DUR;
      TGT_GOOD: return INSTR_PROG_GOOD;
      TGT_BAD:  return INSTR_PROG_BAD;
      default:  return INSTR_NOP;
    endcase
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_slow_tick.sv
// Sweep divider: counts completed sweeps modulo SLOW_DIV and flags the
// sweep that starts at count 0 as a tick sweep (drives clock_slow in EVAL).
module tt_um_jleugeri_ttt_slow_tick #(
  parameter int SLOW_DIV = 16
) (
  input  logic clock_fast,
  input  logic reset_n,
  input  logic sweep_done,
  output logic tick
);

  localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOW_DIV - 1);

  logic [CW-1:0] cnt;

  // Advance the sweep count once per completed sweep, wrapping at SLOW_DIV.
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (sweep_done) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/tt_um_jleugeri_ttt_sequencer.sv
// Sequencer for the time-multiplexed TTT core: INIT sweep of core resets,
// then round-robin UPDATE/EVAL per processor with host writes slotted in at
// processor boundaries and start/stop tokens turned into tagged events.
// Optional macro TTT_SEQ_EVENT_STALL_EN: event backpressure via event_ready
// (CAPTURE stalls while an event is pending); otherwise event_valid pulses.
module tt_um_jleugeri_ttt_sequencer
  import ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS  = 10,
  parameter int ID_BITS         = $clog2(NUM_PROCESSORS),
  parameter int NEW_TOKENS_BITS = 4,
  parameter int PROG_WIDTH      = 8,
  parameter int SLOW_DIV        = 16
) (
  input  logic                       clock_fast,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic                       prog_valid,
  output logic                       prog_ready,
  input  logic [1:0]                 prog_target,
  input  logic [ID_BITS-1:0]         prog_id,
  input  logic [PROG_WIDTH-1:0]      prog_value,
  output logic [ID_BITS-1:0]         tok_id,
  input  logic [NEW_TOKENS_BITS-1:0] tok_good,
  input  logic [NEW_TOKENS_BITS-1:0] tok_bad,
  output logic                       core_reset,
  output logic [ID_BITS-1:0]         processor_id,
  output logic [2:0]                 instruction,
  output logic [PROG_WIDTH-1:0]      prog_data,
  output logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                       clock_slow,
  input  logic [1:0]                 token_startstop,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic [ID_BITS-1:0]         event_id,
  output logic                       event_start
);

  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_PROCESSORS - 1);

  seq_state_t                 state, state_d;
  logic [ID_BITS-1:0]         id, id_d, id_inc;
  logic                       last_id;
  logic [1:0]                 prog_tgt_q;
  logic [ID_BITS-1:0]         prog_id_q;
  logic [PROG_WIDTH-1:0]      prog_val_q;
  logic [NEW_TOKENS_BITS-1:0] good_q, bad_q;
  logic                       tick, sweep_done;
  logic                       ev_new, stall;

  assign last_id = (id == LAST_ID);
  assign id_inc  = last_id ? '0 : id + 1'b1;
  assign ev_new  = (state == ST_CAPTURE) &&
                   (token_startstop == SS_START || token_startstop == SS_STOP);

`ifdef TTT_SEQ_EVENT_STALL_EN
  assign stall = ev_new && event_valid && !event_ready;
`else
  // Without backpressure the consumer handshake is not used.
  logic unused_event_ready;
  assign unused_event_ready = event_ready;
  assign stall = 1'b0;
`endif

  tt_um_jleugeri_ttt_slow_tick #(.SLOW_DIV(SLOW_DIV)) u_slow_tick (
    .clock_fast (clock_fast),
    .reset_n    (reset_n),
    .sweep_done (sweep_done),
    .tick       (tick)
  );

  // State and sweep id register.
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      id    <= '0;
    end else begin
      state <= state_d;
      id    <= id_d;
    end
  end

  // Next state plus all core-facing outputs decoded from the current state.
  always_comb begin
    state_d         = state;
    id_d            = id;
    core_reset      = 1'b0;
    processor_id    = id;
    instruction     = INSTR_NOP;
    prog_data       = '0;
    new_good_tokens = '0;
    new_bad_tokens  = '0;
    clock_slow      = 1'b0;
    tok_id          = '0;
    prog_ready      = 1'b0;
    sweep_done      = 1'b0;
    unique case (state)
      ST_INIT: begin
        core_reset = 1'b1;
        id_d       = id_inc;
        if (last_id) state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        tok_id = id;
        if (prog_valid) begin
          prog_ready = 1'b1;
          state_d    = ST_PROG;
        end else if (run) begin
          state_d = ST_UPDATE;
        end
      end
      ST_PROG: begin
        processor_id = prog_id_q;
        prog_data    = prog_val_q;
        // Out-of-range ids are dropped as a NOP rather than aliasing.
        instruction  = (int'(prog_id_q) < NUM_PROCESSORS) ? prog_instr(prog_tgt_q)
                                                         : INSTR_NOP;
        state_d      = ST_DISPATCH;
      end
      ST_UPDATE: begin
        instruction     = INSTR_UPDATE;
        new_good_tokens = good_q;
        new_bad_tokens  = bad_q;
        state_d         = ST_EVAL;
      end
      ST_EVAL: begin
        instruction = INSTR_EVAL;
        clock_slow  = tick;
        state_d     = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!stall) begin
          id_d       = id_inc;
          sweep_done = last_id;
          state_d    = ST_DISPATCH;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Token increments and host writes are latched while dispatching.
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      good_q     <= '0;
      bad_q      <= '0;
      prog_tgt_q <= '0;
      prog_id_q  <= '0;
      prog_val_q <= '0;
    end else if (state == ST_DISPATCH) begin
      good_q <= tok_good;
      bad_q  <= tok_bad;
      if (prog_valid) begin
        prog_tgt_q <= prog_target;
        prog_id_q  <= prog_id;
        prog_val_q <= prog_value;
      end
    end
  end

  // Event register: load on a captured start/stop token, clear on handoff.
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      event_valid <= 1'b0;
      event_id    <= '0;
      event_start <= 1'b0;
    end else begin
`ifdef TTT_SEQ_EVENT_STALL_EN
      if (ev_new && !stall) begin
        event_valid <= 1'b1;
        event_id    <= id;
        event_start <= token_startstop[1];
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
`else
      event_valid <= ev_new;
      if (ev_new) begin
        event_id    <= id;
        event_start <= token_startstop[1];
      end
`endif
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_sequencer.sv
// Randomized bench for the TTT sequencer. The reference model tracks a
// position k in the undisturbed sweep schedule (4 cycles per processor) and
// derives processor, phase and tick sweep arithmetically; host writes and
// event stalls are modelled as inserted cycles that do not advance k.
module tb_tt_um_jleugeri_ttt_sequencer;

  localparam int N    = 10;
  localparam int IDB  = 4;
  localparam int TB   = 4;
  localparam int PW   = 8;
  localparam int SDIV = 2;
  localparam int NCYC = 3000;

  logic            clock_fast = 1'b0;
  logic            reset_n;
  logic            run, prog_valid, prog_ready;
  logic [1:0]      prog_target;
  logic [IDB-1:0]  prog_id, tok_id, processor_id, event_id;
  logic [PW-1:0]   prog_value, prog_data;
  logic [TB-1:0]   tok_good, tok_bad, new_good_tokens, new_bad_tokens;
  logic            core_reset, clock_slow;
  logic [2:0]      instruction;
  logic [1:0]      token_startstop;
  logic            event_valid, event_ready, event_start;

  tt_um_jleugeri_ttt_sequencer #(
    .NUM_PROCESSORS(N), .NEW_TOKENS_BITS(TB), .PROG_WIDTH(PW), .SLOW_DIV(SDIV)
  ) dut (
    .clock_fast(clock_fast), .reset_n(reset_n), .run(run),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_target(prog_target),
    .prog_id(prog_id), .prog_value(prog_value), .tok_id(tok_id),
    .tok_good(tok_good), .tok_bad(tok_bad), .core_reset(core_reset),
    .processor_id(processor_id), .instruction(instruction), .prog_data(prog_data),
    .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
    .clock_slow(clock_slow), .token_startstop(token_startstop),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_id(event_id), .event_start(event_start)
  );

  always #5 clock_fast = ~clock_fast;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit             running, inprog, pend, e_start;
  int             init_k, k;
  logic [1:0]     p_tgt;
  logic [IDB-1:0] p_id, e_id;
  logic [PW-1:0]  p_val;
  logic [TB-1:0]  g_m, b_m;

  task automatic model_reset();
    running = 0; inprog = 0; pend = 0; e_start = 0;
    init_k = 0; k = 0; g_m = '0; b_m = '0; e_id = '0;
  endtask

  function automatic int exp_prog_instr(input logic [1:0] tgt, input logic [IDB-1:0] pid);
    if (int'(pid) >= N) return 0;
    case (tgt)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check_outputs();
    int proc, ph;
    bit tick;
    if (!running) begin
      chk("init_core_reset", core_reset, 1);
      chk("init_pid", processor_id, init_k);
      chk("init_instr", instruction, 0);
      chk("init_clock_slow", clock_slow, 0);
      chk("init_prog_ready", prog_ready, 0);
    end else if (inprog) begin
      chk("prog_instr", instruction, exp_prog_instr(p_tgt, p_id));
      chk("prog_pid", processor_id, p_id);
      chk("prog_data", prog_data, p_val);
      chk("prog_core_reset", core_reset, 0);
      chk("prog_ready_in_prog", prog_ready, 0);
    end else begin
      proc = (k / 4) % N;
      ph   = k % 4;
      tick = ((k / (4 * N)) % SDIV) == 0;
      chk("run_core_reset", core_reset, 0);
      case (ph)
        0: begin
          chk("disp_instr", instruction, 0);
          chk("disp_tok_id", tok_id, proc);
          chk("disp_prog_ready", prog_ready, prog_valid);
        end
        1: begin
          chk("upd_instr", instruction, 4);
          chk("upd_pid", processor_id, proc);
          chk("upd_good", new_good_tokens, g_m);
          chk("upd_bad", new_bad_tokens, b_m);
        end
        2: begin
          chk("eval_instr", instruction, 5);
          chk("eval_pid", processor_id, proc);
          chk("eval_clock_slow", clock_slow, tick);
        end
        default: begin
          chk("cap_instr", instruction, 0);
          chk("cap_clock_slow", clock_slow, 0);
        end
      endcase
      if (ph != 0) chk("prog_ready_idle", prog_ready, 0);
    end
    chk("event_valid", event_valid, pend);
    if (pend) begin
      chk("event_id", event_id, e_id);
      chk("event_start", event_start, e_start);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit is_cap, ev, stall;
    int proc;
    is_cap = running && !inprog && (k % 4 == 3);
    ev     = is_cap && (token_startstop == 2'b10 || token_startstop == 2'b01);
    proc   = (k / 4) % N;
`ifdef TTT_SEQ_EVENT_STALL_EN
    stall = ev && pend && !event_ready;
    if (ev && !stall) begin
      pend = 1; e_id = IDB'(proc); e_start = token_startstop[1];
    end else if (pend && event_ready) begin
      pend = 0;
    end
`else
    stall = 0;
    pend  = ev;
    if (ev) begin
      e_id = IDB'(proc); e_start = token_startstop[1];
    end
`endif
    if (!running) begin
      init_k++;
      if (init_k == N) begin running = 1; k = 0; end
    end else if (inprog) begin
      inprog = 0;
    end else begin
      case (k % 4)
        0: begin
          g_m = tok_good; b_m = tok_bad;
          if (prog_valid) begin
            inprog = 1; p_tgt = prog_target; p_id = prog_id; p_val = prog_value;
          end else if (run) begin
            k++;
          end
        end
        3:       if (!stall) k++;
        default: k++;
      endcase
    end
  endtask

  initial begin
    bit did_rst = 0;
    reset_n = 1'b0;
    run = 0; prog_valid = 0; prog_target = '0; prog_id = '0; prog_value = '0;
    tok_good = '0; tok_bad = '0; token_startstop = '0; event_ready = 0;
    model_reset();
    repeat (3) @(negedge clock_fast);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_instr", instruction, 0);
    chk("rst_event_valid", event_valid, 0);
    chk("rst_clock_slow", clock_slow, 0);
    chk("rst_pid", processor_id, 0);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc != 0) @(negedge clock_fast);
      if (!did_rst && cyc > 1500 && running && !inprog && (k % 4 == 2)) begin
        reset_n = 1'b0;
        #1;
        chk("midrst_instr", instruction, 0);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_event_valid", event_valid, 0);
        model_reset();
        @(posedge clock_fast);
        @(negedge clock_fast);
        reset_n = 1'b1;
        did_rst = 1;
      end
      run             = ($urandom_range(0, 4) != 0);
      prog_valid      = ($urandom_range(0, 7) == 0);
      prog_target     = 2'($urandom);
      prog_id         = IDB'($urandom);
      prog_value      = PW'($urandom);
      tok_good        = TB'($urandom);
      tok_bad         = TB'($urandom);
      token_startstop = 2'($urandom);
      event_ready     = 1'($urandom);
      #1;
      check_outputs();
      model_step();
    end
    chk("mid_reset_exercised", did_rst, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
